addsub_arbiter: RTL

Sequencing controller that time-shares one external 4-bit ripple add/subtract datapath between two requesters. It accepts one operation at a time through a valid/ready handshake and arbitrates round-robin when both requesters are active. It drives the datapath's operand and mode inputs from registers, captures its sum and carry, and returns the result with the requester ID through a valid/ready response port. It sits between the counter/accumulator logic and the shared adder/subtractor instance.

---
 rtl/addsub_arbiter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/addsub_arbiter.sv
// Round-robin sequencer that time-shares one external add/subtract datapath between two requesters.
// Optional feature macro: ADDSUB_ARB_OVF_EN adds the registered two's-complement overflow output rsp_ovf.
module addsub_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic             r0_sub,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic             r1_sub,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic [WIDTH-1:0] dp_a,
  output logic [WIDTH-1:0] dp_b,
  output logic             dp_sel,
  input  logic [WIDTH-1:0] dp_result,
  input  logic             dp_carry
`ifdef ADDSUB_ARB_OVF_EN
  ,
  output logic             rsp_ovf
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPERATE = 2'd1,
    RESP    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_id_q, last_id_d;
  logic [WIDTH-1:0] dp_a_q, dp_a_d;
  logic [WIDTH-1:0] dp_b_q, dp_b_d;
  logic             dp_sel_q, dp_sel_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic             grant0_s, grant1_s;

`ifdef ADDSUB_ARB_OVF_EN
  logic             rsp_ovf_q, rsp_ovf_d;

  // Signed overflow: operands agree in sign (add) or differ (subtract) and the result sign flips.
  function automatic logic ovf_calc(input logic a_msb, input logic b_msb,
                                    input logic sub, input logic res_msb);
    logic sign_cond;
    sign_cond = sub ? (a_msb != b_msb) : (a_msb == b_msb);
    return sign_cond && (res_msb != a_msb);
  endfunction
`endif

  // Grant selection: single valid requester wins; on a tie the one not served last wins.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (rst_n && (state_q == IDLE)) begin
      if (r0_valid && r1_valid) begin
        grant0_s = last_id_q;
        grant1_s = !last_id_q;
      end else begin
        grant0_s = r0_valid;
        grant1_s = r1_valid;
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  assign r0_ready = grant0_s;
  assign r1_ready = grant1_s;

  // Next-state and next-register computation for the IDLE/OPERATE/RESP sequence.
  always_comb begin
    state_d      = state_q;
    last_id_d    = last_id_q;
    dp_a_d       = dp_a_q;
    dp_b_d       = dp_b_q;
    dp_sel_d     = dp_sel_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
`ifdef ADDSUB_ARB_OVF_EN
    rsp_ovf_d    = rsp_ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant0_s) begin
          dp_a_d    = r0_a;
          dp_b_d    = r0_b;
          dp_sel_d  = r0_sub;
          rsp_id_d  = 1'b0;
          last_id_d = 1'b0;
          state_d   = OPERATE;
        end else if (grant1_s) begin
          dp_a_d    = r1_a;
          dp_b_d    = r1_b;
          dp_sel_d  = r1_sub;
          rsp_id_d  = 1'b1;
          last_id_d = 1'b1;
          state_d   = OPERATE;
        end else begin
          state_d = IDLE;
        end
      end
      OPERATE: begin
        // The ripple has had a full cycle from the registered operands; capture it now.
        rsp_result_d = dp_result;
        rsp_carry_d  = dp_carry;
        rsp_valid_d  = 1'b1;
`ifdef ADDSUB_ARB_OVF_EN
        rsp_ovf_d    = ovf_calc(dp_a_q[WIDTH-1], dp_b_q[WIDTH-1], dp_sel_q, dp_result[WIDTH-1]);
`endif
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_id_q    <= 1'b1;
      dp_a_q       <= {WIDTH{1'b0}};
      dp_b_q       <= {WIDTH{1'b0}};
      dp_sel_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= {WIDTH{1'b0}};
      rsp_carry_q  <= 1'b0;
`ifdef ADDSUB_ARB_OVF_EN
      rsp_ovf_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_id_q    <= last_id_d;
      dp_a_q       <= dp_a_d;
      dp_b_q       <= dp_b_d;
      dp_sel_q     <= dp_sel_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
`ifdef ADDSUB_ARB_OVF_EN
      rsp_ovf_q    <= rsp_ovf_d;
`endif
    end
  end

  assign dp_a       = dp_a_q;
  assign dp_b       = dp_b_q;
  assign dp_sel     = dp_sel_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_carry  = rsp_carry_q;
`ifdef ADDSUB_ARB_OVF_EN
  assign rsp_ovf    = rsp_ovf_q;
`endif

endmodule
